// File: rtl/trend_detect.sv
// trend_detect
//   Classifies each accepted sample against the previously accepted sample
//   as FLAT, UP (+1), DOWN (-1) or ERR (any larger step). It also tracks the
//   length of the current run of identical classifications and a total count
//   of ERR classifications. All outputs are registered and appear one cycle
//   after the sample that produced them.
//
// Parameters
//   WIDTH   sample width (2..16)
//   RUN_W   width of run_len / err_cnt (both saturate at all-ones)
//   WRAP_EN 1: +1/-1 steps wrap modulo 2^WIDTH; 0: max->0 and 0->max are ERR
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   data_valid sample qualifier
//   data       sample value
//   clear      synchronous clear of history, outputs and counters (beats data_valid)
//   incr/decr/error  one-hot (or all-zero) classification of the last sample
//   out_valid  one-cycle pulse after each accepted sample
//   run_len    consecutive samples with the same classification
//   err_cnt    total ERR classifications since reset/clear
//   trend      state: EMPTY=0 FLAT=1 UP=2 DOWN=3 ERR=4
module trend_detect #(
  parameter int WIDTH   = 4,
  parameter int RUN_W   = 4,
  parameter int WRAP_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             incr,
  output logic             decr,
  output logic             error,
  output logic             out_valid,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] err_cnt,
  output logic [2:0]       trend
);

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    FLAT  = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [RUN_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] CNT_ONE = RUN_W'(1);

  state_t             state_reg, state_next;
  state_t             cls;
  logic [WIDTH-1:0]   prev_reg, prev_next;
  logic               incr_reg, incr_next;
  logic               decr_reg, decr_next;
  logic               error_reg, error_next;
  logic               out_valid_reg, out_valid_next;
  logic [RUN_W-1:0]   run_len_reg, run_len_next;
  logic [RUN_W-1:0]   err_cnt_reg, err_cnt_next;
  logic               is_up, is_down;

  // Step detection. The wrapping form compares in WIDTH bits so the +/-1
  // naturally rolls over; the linear form adds a guard bit so a rollover
  // produces a value no WIDTH-bit sample can equal.
  generate
    if (WRAP_EN != 0) begin : g_wrap
      logic [WIDTH-1:0] prev_inc, prev_dec;
      assign prev_inc = prev_reg + 1'b1;
      assign prev_dec = prev_reg - 1'b1;
      assign is_up    = (data == prev_inc);
      assign is_down  = (data == prev_dec);
    end else begin : g_linear
      logic [WIDTH:0] data_ext, prev_ext, prev_inc, prev_dec;
      assign data_ext = {1'b0, data};
      assign prev_ext = {1'b0, prev_reg};
      assign prev_inc = prev_ext + 1'b1;
      assign prev_dec = prev_ext - 1'b1;
      assign is_up    = (data_ext == prev_inc);
      assign is_down  = (data_ext == prev_dec);
    end
  endgenerate

  // Classification in priority order: equal, +1, -1, anything else.
  always_comb begin
    cls = ERR;
    if (data == prev_reg) begin
      cls = FLAT;
    end else if (is_up) begin
      cls = UP;
    end else if (is_down) begin
      cls = DOWN;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    run_len_next   = run_len_reg;
    err_cnt_next   = err_cnt_reg;
    out_valid_next = 1'b0;

    if (clear) begin
      state_next   = EMPTY;
      run_len_next = '0;
      err_cnt_next = '0;
    end else if (data_valid) begin
      out_valid_next = 1'b1;
      prev_next      = data;
      if (state_reg == EMPTY) begin
        // First sample only seeds the history; nothing to compare against.
        state_next   = FLAT;
        run_len_next = '0;
      end else begin
        state_next = cls;
        if (cls == state_reg) begin
          if (run_len_reg != CNT_MAX) begin
            run_len_next = run_len_reg + 1'b1;
          end
        end else begin
          run_len_next = CNT_ONE;
        end
        if ((cls == ERR) && (err_cnt_reg != CNT_MAX)) begin
          err_cnt_next = err_cnt_reg + 1'b1;
        end
      end
    end

    // Flags are a pure function of the next state, so they hold together
    // with the state when no sample is accepted.
    incr_next  = (state_next == UP);
    decr_next  = (state_next == DOWN);
    error_next = (state_next == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      prev_reg      <= '0;
      incr_reg      <= 1'b0;
      decr_reg      <= 1'b0;
      error_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      run_len_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      incr_reg      <= incr_next;
      decr_reg      <= decr_next;
      error_reg     <= error_next;
      out_valid_reg <= out_valid_next;
      run_len_reg   <= run_len_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign incr      = incr_reg;
  assign decr      = decr_reg;
  assign error     = error_reg;
  assign out_valid = out_valid_reg;
  assign run_len   = run_len_reg;
  assign err_cnt   = err_cnt_reg;
  assign trend     = state_reg;

endmodule

// File: tb/tb_trend_detect.sv
// Testbench for trend_detect. Three instances share one stimulus stream:
//   dut 0: WRAP_EN=1 RUN_W=4, dut 1: WRAP_EN=0 RUN_W=4, dut 2: WRAP_EN=1 RUN_W=2.
// Outputs are compared as a packed word {incr,decr,error,out_valid,run_len[3:0],
// err_cnt[3:0],trend[2:0]} against a table, hand sequences and a reference model.
module tb_trend_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid;
  logic       clear;
  logic [3:0] data;

  always #5 clk = ~clk;

  logic       incr_a, decr_a, error_a, ov_a;
  logic [3:0] run_a, err_a;
  logic [2:0] trend_a;
  logic       incr_b, decr_b, error_b, ov_b;
  logic [3:0] run_b, err_b;
  logic [2:0] trend_b;
  logic       incr_c, decr_c, error_c, ov_c;
  logic [1:0] run_c, err_c;
  logic [2:0] trend_c;

  trend_detect #(.WIDTH(4), .RUN_W(4), .WRAP_EN(1)) dut_a (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data(data), .clear(clear),
    .incr(incr_a), .decr(decr_a), .error(error_a), .out_valid(ov_a),
    .run_len(run_a), .err_cnt(err_a), .trend(trend_a));

  trend_detect #(.WIDTH(4), .RUN_W(4), .WRAP_EN(0)) dut_b (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data(data), .clear(clear),
    .incr(incr_b), .decr(decr_b), .error(error_b), .out_valid(ov_b),
    .run_len(run_b), .err_cnt(err_b), .trend(trend_b));

  trend_detect #(.WIDTH(4), .RUN_W(2), .WRAP_EN(1)) dut_c (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data(data), .clear(clear),
    .incr(incr_c), .decr(decr_c), .error(error_c), .out_valid(ov_c),
    .run_len(run_c), .err_cnt(err_c), .trend(trend_c));

  int checks   = 0;
  int failures = 0;

  function automatic logic [14:0] pk(input logic i, input logic d, input logic e,
                                     input logic ov, input int run, input int err,
                                     input int tr);
    logic [3:0] r4, e4;
    logic [2:0] t3;
    r4 = run[3:0];
    e4 = err[3:0];
    t3 = tr[2:0];
    return {i, d, e, ov, r4, e4, t3};
  endfunction

  function automatic logic [14:0] obs(input int k);
    if (k == 0) return {incr_a, decr_a, error_a, ov_a, run_a, err_a, trend_a};
    if (k == 1) return {incr_b, decr_b, error_b, ov_b, run_b, err_b, trend_b};
    return {incr_c, decr_c, error_c, ov_c, 2'b00, run_c, 2'b00, err_c, trend_c};
  endfunction

  task automatic check(input string name, input int k, input logic [14:0] exp);
    logic [14:0] act;
    act = obs(k);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h (i,d,e,ov,run,err,trend)",
               name, k, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Classes: 0 empty, 1 flat, 2 up, 3 down, 4 err
  int m_have[3], m_prev[3], m_cls[3], m_run[3], m_err[3], m_ov[3];
  int m_wrap[3] = '{1, 0, 1};
  int m_rmax[3] = '{15, 15, 3};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_have[k] = 0; m_prev[k] = 0; m_cls[k] = 0;
      m_run[k] = 0; m_err[k] = 0; m_ov[k] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic c, input int d);
    int nc, up_val, dn_val;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_have[k] = 0; m_cls[k] = 0; m_run[k] = 0; m_err[k] = 0; m_ov[k] = 0;
      end else if (v) begin
        m_ov[k] = 1;
        if (m_have[k] == 0) begin
          m_have[k] = 1; m_cls[k] = 1; m_run[k] = 0;
        end else begin
          up_val = m_prev[k] + 1;
          dn_val = m_prev[k] - 1;
          if (m_wrap[k] != 0) begin
            up_val = up_val % 16;
            dn_val = (dn_val + 16) % 16;
          end
          if (d == m_prev[k]) nc = 1;
          else if (d == up_val) nc = 2;
          else if (d == dn_val) nc = 3;
          else nc = 4;
          if (nc == m_cls[k]) m_run[k] = (m_run[k] < m_rmax[k]) ? m_run[k] + 1 : m_run[k];
          else m_run[k] = 1;
          if (nc == 4 && m_err[k] < m_rmax[k]) m_err[k]++;
          m_cls[k] = nc;
        end
        m_prev[k] = d;
      end else begin
        m_ov[k] = 0;
      end
    end
  endtask

  function automatic logic [14:0] model_exp(input int k);
    return pk(m_cls[k] == 2, m_cls[k] == 3, m_cls[k] == 4, m_ov[k] != 0,
              m_run[k], m_err[k], m_cls[k]);
  endfunction

  // One accepted/idle cycle: drive, clock, then check all DUTs against the model.
  task automatic step(input logic v, input logic c, input logic [3:0] d);
    data_valid = v;
    clear      = c;
    data       = d;
    @(posedge clk);
    #1;
    model_step(v, c, int'(d));
    for (int k = 0; k < 3; k++) check("model", k, model_exp(k));
  endtask

  typedef struct {
    logic        v;
    logic        c;
    logic [3:0]  d;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic c, input int d, input logic [14:0] exp);
    vec_t r;
    logic [3:0] d4;
    d4 = d[3:0];
    r.v = v; r.c = c; r.d = d4; r.exp = exp;
    return r;
  endfunction

  initial begin
    int r, d;
    logic v, c;

    reset = 1'b1; data_valid = 1'b0; clear = 1'b0; data = '0;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) check("reset_async", k, 15'd0);
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check("reset_hold", k, 15'd0);
    reset = 1'b0;

    // Table for dut 0 (WRAP_EN=1, RUN_W=4)
    tbl.push_back(mk(1, 0, 3,  pk(0,0,0,1,0,0,1)));
    tbl.push_back(mk(1, 0, 4,  pk(1,0,0,1,1,0,2)));
    tbl.push_back(mk(1, 0, 5,  pk(1,0,0,1,2,0,2)));
    tbl.push_back(mk(1, 0, 6,  pk(1,0,0,1,3,0,2)));
    tbl.push_back(mk(0, 1, 0,  pk(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1, 0, 9,  pk(0,0,0,1,0,0,1)));
    tbl.push_back(mk(1, 0, 8,  pk(0,1,0,1,1,0,3)));
    tbl.push_back(mk(1, 0, 8,  pk(0,0,0,1,1,0,1)));
    tbl.push_back(mk(1, 0, 12, pk(0,0,1,1,1,1,4)));
    tbl.push_back(mk(0, 1, 0,  pk(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1, 0, 5,  pk(0,0,0,1,0,0,1)));
    tbl.push_back(mk(1, 1, 6,  pk(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1, 0, 7,  pk(0,0,0,1,0,0,1)));
    tbl.push_back(mk(0, 1, 0,  pk(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1, 0, 2,  pk(0,0,0,1,0,0,1)));
    tbl.push_back(mk(1, 0, 3,  pk(1,0,0,1,1,0,2)));
    tbl.push_back(mk(0, 0, 9,  pk(1,0,0,0,1,0,2)));
    tbl.push_back(mk(0, 0, 0,  pk(1,0,0,0,1,0,2)));
    tbl.push_back(mk(0, 0, 5,  pk(1,0,0,0,1,0,2)));
    tbl.push_back(mk(1, 0, 4,  pk(1,0,0,1,2,0,2)));
    tbl.push_back(mk(1, 0, 4,  pk(0,0,0,1,1,0,1)));
    tbl.push_back(mk(1, 0, 4,  pk(0,0,0,1,2,0,1)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].d);
      check($sformatf("tbl[%0d]", i), 0, tbl[i].exp);
      $display("vec %0d v=%0d c=%0d d=%0d out=%h", i, tbl[i].v, tbl[i].c, tbl[i].d, obs(0));
    end

    // Wrap vs linear at the range ends
    step(0, 1, 0);
    step(1, 0, 15);
    check("wrap_first", 0, pk(0,0,0,1,0,0,1));
    step(1, 0, 0);
    check("wrap_15_0", 0, pk(1,0,0,1,1,0,2));
    check("lin_15_0", 1, pk(0,0,1,1,1,1,4));
    step(1, 0, 15);
    check("wrap_0_15", 0, pk(0,1,0,1,1,0,3));
    check("lin_0_15", 1, pk(0,0,1,1,2,2,4));
    $display("seq wrap: dut0=%h dut1=%h", obs(0), obs(1));

    // Saturation with RUN_W=2
    step(0, 1, 0);
    for (int i = 0; i <= 6; i++) step(1, 0, 4'(i));
    check("sat_run", 2, pk(1,0,0,1,3,0,2));
    check("nosat_run", 0, pk(1,0,0,1,6,0,2));
    step(1, 0, 0); step(1, 0, 8); step(1, 0, 0); step(1, 0, 8); step(1, 0, 0);
    check("sat_err", 2, pk(0,0,1,1,3,3,4));
    check("nosat_err", 0, pk(0,0,1,1,5,5,4));
    $display("seq sat: dut0=%h dut2=%h", obs(0), obs(2));

    // Reset mid-stream: immediate clear, history discarded
    step(1, 0, 3);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("reset_mid", k, 15'd0);
    data_valid = 1'b1; data = 4'd9;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check("reset_mid_edge", k, 15'd0);
    reset = 1'b0;
    model_reset();
    step(1, 0, 4);
    check("after_reset", 0, pk(0,0,0,1,0,0,1));
    $display("seq reset: dut0=%h", obs(0));

    // Randomized stream against the reference model
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 3);
      if (r == 0) d = m_prev[0];
      else if (r == 1) d = (m_prev[0] + 1) % 16;
      else if (r == 2) d = (m_prev[0] + 15) % 16;
      else d = $urandom_range(0, 15);
      step(v, c, 4'(d));
      $display("rnd %0d v=%0d c=%0d d=%0d out0=%h out1=%h out2=%h",
               i, v, c, d, obs(0), obs(1), obs(2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
